// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_INIT_WAIT,
        ST_RELEASE,
        ST_DONE,
        ST_SOFT_ASSERT,
        ST_SOFT_HOLD
    } reset_seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the rest of its clock domain.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  sync_reset_in;
    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  reset_done;
    logic                  seq_busy;

    modport master (
        output sync_reset_in,
        output soft_reset_req,
        input  stage_rst_n,
        input  reset_done,
        input  seq_busy
    );

    modport slave (
        input  sync_reset_in,
        input  soft_reset_req,
        output stage_rst_n,
        output reset_done,
        output seq_busy
    );
endinterface

// File: rtl/reset_seq_delay_counter.sv
// Loadable down-counter that stops at zero and flags it; used to time every sequencer gap.
module reset_seq_delay_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock_domain,
    input  logic             async_reset_in,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock_domain or negedge async_reset_in) begin
        if (!async_reset_in) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with soft-reset support. Define RESET_SEQ_REVERSE_ASSERT_EN for
// graceful reverse-order stage assertion on soft reset instead of asserting all at once.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int INIT_DELAY  = 16,
    parameter int STAGE_DELAY = 8,
    parameter int SOFT_HOLD   = 4
) (
    input  logic              clock_domain,
    input  logic              async_reset_in,
    reset_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(max3(INIT_DELAY, STAGE_DELAY, SOFT_HOLD) + 1);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    // Gaps are loaded one short so the zero flag is seen on the edge that ends the gap.
    localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0] STAGE_LD = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] SOFT_LD  = CNT_W'(SOFT_HOLD - 1);

    reset_seq_state_t      r_state;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic                  r_reset_done;
    logic [IDX_W-1:0]      r_idx;

    reset_seq_state_t      w_state_nxt;
    logic [NUM_STAGES-1:0] w_stage_nxt;
    logic                  w_done_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_cnt_load;
    logic [CNT_W-1:0]      w_cnt_val;
    logic                  w_cnt_zero;

    reset_seq_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clock_domain   (clock_domain),
        .async_reset_in (async_reset_in),
        .i_load         (w_cnt_load),
        .i_load_val     (w_cnt_val),
        .o_zero         (w_cnt_zero)
    );

    always_ff @(posedge clock_domain or negedge async_reset_in) begin
        if (!async_reset_in) begin
            r_state       <= ST_HOLD;
            r_stage_rst_n <= '0;
            r_reset_done  <= 1'b0;
            r_idx         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_stage_rst_n <= w_stage_nxt;
            r_reset_done  <= w_done_nxt;
            r_idx         <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage_rst_n;
        w_done_nxt  = r_reset_done;
        w_idx_nxt   = r_idx;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;

        // Loss of the upstream reset release wins over everything, including soft requests.
        if ((r_state != ST_HOLD) && !bus.sync_reset_in) begin
            w_state_nxt = ST_HOLD;
            w_stage_nxt = '0;
            w_done_nxt  = 1'b0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (bus.sync_reset_in) begin
                        w_state_nxt = ST_INIT_WAIT;
                        w_idx_nxt   = '0;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = INIT_LD;
                    end
                end
                ST_INIT_WAIT, ST_RELEASE: begin
                    if (w_cnt_zero) begin
                        w_stage_nxt[r_idx] = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_cnt_load  = 1'b1;
                            w_cnt_val   = STAGE_LD;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.soft_reset_req) begin
                        w_done_nxt = 1'b0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                        w_stage_nxt[LAST_IDX] = 1'b0;
                        w_cnt_load            = 1'b1;
                        if (NUM_STAGES == 1) begin
                            w_state_nxt = ST_SOFT_HOLD;
                            w_cnt_val   = SOFT_LD;
                        end else begin
                            w_state_nxt = ST_SOFT_ASSERT;
                            w_idx_nxt   = LAST_IDX - IDX_W'(1);
                            w_cnt_val   = STAGE_LD;
                        end
`else
                        w_stage_nxt = '0;
                        w_state_nxt = ST_SOFT_HOLD;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = SOFT_LD;
`endif
                    end
                end
                ST_SOFT_ASSERT: begin
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                    if (w_cnt_zero) begin
                        w_stage_nxt[r_idx] = 1'b0;
                        w_cnt_load         = 1'b1;
                        if (r_idx == '0) begin
                            w_state_nxt = ST_SOFT_HOLD;
                            w_cnt_val   = SOFT_LD;
                        end else begin
                            w_idx_nxt = r_idx - IDX_W'(1);
                            w_cnt_val = STAGE_LD;
                        end
                    end
`else
                    w_state_nxt = ST_HOLD;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
`endif
                end
                ST_SOFT_HOLD: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = ST_INIT_WAIT;
                        w_idx_nxt   = '0;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = INIT_LD;
                    end
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.stage_rst_n = r_stage_rst_n;
    assign bus.reset_done  = r_reset_done;
    assign bus.seq_busy    = (r_state != ST_DONE);
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timestamp-based model predicts each edge's outputs.
module tb_reset_sequencer;
    localparam int N    = 3;
    localparam int INIT = 4;
    localparam int STG  = 2;
    localparam int SH   = 3;
    localparam int FULL = INIT + (N - 1) * STG;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    localparam bit REV       = 1'b1;
    localparam int SOFT_LEAD = (N - 1) * STG + SH;
`else
    localparam bit REV       = 1'b0;
    localparam int SOFT_LEAD = SH;
`endif

    typedef struct {
        int           cyc;
        logic [N-1:0] stg;
        logic         done;
        logic         busy;
    } exp_t;

    logic clk;
    logic clk_en;
    logic arst_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t q[$];
    exp_t mon_e;

    int m_t0;
    int m_e;
    bit m_prev_done;

    reset_sequencer_if #(.NUM_STAGES(N)) rs_if ();

    reset_sequencer #(
        .NUM_STAGES  (N),
        .INIT_DELAY  (INIT),
        .STAGE_DELAY (STG),
        .SOFT_HOLD   (SH)
    ) dut (
        .clock_domain   (clk),
        .async_reset_in (arst_n),
        .bus            (rs_if)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5 clk = clk_en ? ~clk : 1'b0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_t0        = -1;
        m_e         = -1;
        m_prev_done = 1'b0;
    endtask

    // Predicts outputs after edge c from release/soft timestamps rather than FSM states.
    task automatic model_edge(input int c, input bit s, input bit r, output exp_t x);
        if (!s) begin
            m_t0 = -1;
            m_e  = -1;
        end else if (m_t0 < 0) begin
            m_t0 = c;
        end else if (m_prev_done && r) begin
            m_e  = c;
            m_t0 = c + SOFT_LEAD;
        end
        x.cyc = c;
        for (int k = 0; k < N; k++) begin
            if (m_t0 < 0)
                x.stg[k] = 1'b0;
            else if (REV && m_e >= 0 && c < m_e + (N - 1) * STG)
                x.stg[k] = (c < m_e + (N - 1 - k) * STG);
            else
                x.stg[k] = (c >= m_t0 + INIT + k * STG);
        end
        x.done      = (m_t0 >= 0) && (c >= m_t0 + FULL);
        x.busy      = ~x.done;
        m_prev_done = x.done;
    endtask

    task automatic step(input bit s, input bit r);
        exp_t x;
        rs_if.sync_reset_in  = s;
        rs_if.soft_reset_req = r;
        model_edge(cyc + 1, s, r, x);
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            if (q[0].cyc == cyc) begin
                mon_e = q.pop_front();
                chk("stage_rst_n", 32'(rs_if.stage_rst_n), 32'(mon_e.stg));
                chk("reset_done", 32'(rs_if.reset_done), 32'(mon_e.done));
                chk("seq_busy", 32'(rs_if.seq_busy), 32'(mon_e.busy));
            end else if (q[0].cyc < cyc) begin
                mon_e = q.pop_front();
                chk("missed_sample", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc    = 0;
        tests  = 0;
        fails  = 0;
        clk_en = 1'b1;
        arst_n = 1'b0;
        rs_if.sync_reset_in  = 1'b0;
        rs_if.soft_reset_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_stage", 32'(rs_if.stage_rst_n), 32'd0);
        chk("reset_done0", 32'(rs_if.reset_done), 32'd0);
        chk("reset_busy", 32'(rs_if.seq_busy), 32'd1);
        arst_n = 1'b1;

        // Power-up release, with a soft request pulsed during INIT_WAIT
        repeat (3) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);

        // Single soft reset from DONE
        step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);

        // Upstream reset re-asserted at T0+7, then released again
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);

        // Async reset at T0+5 with the clock stopped
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        clk_en = 1'b0;
        #10;
        arst_n = 1'b0;
        #1;
        chk("async_stage", 32'(rs_if.stage_rst_n), 32'd0);
        chk("async_done", 32'(rs_if.reset_done), 32'd0);
        chk("async_busy", 32'(rs_if.seq_busy), 32'd1);
        model_reset();
        #4 arst_n = 1'b1;
        #1 clk_en = 1'b1;
        repeat (12) step(1'b1, 1'b0);

        // Soft request held high through several DONE entries
        repeat (60) step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);

        // Randomized mix of upstream drops and soft requests
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0));
        end

        repeat (2) step(1'b1, 1'b0);
        #10;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
